// File: rtl/div_hilo_ctrl_if.sv
// Request channel from the execute stage to the HI/LO divide sequencer.
interface div_hilo_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_signed;
  logic [31:0] req_a;
  logic [31:0] req_b;

  // Execute stage drives requests and observes ready.
  modport master (
    output req_valid,
    output req_signed,
    output req_a,
    output req_b,
    input  req_ready
  );

  // Sequencer accepts requests and drives ready.
  modport slave (
    input  req_valid,
    input  req_signed,
    input  req_a,
    input  req_b,
    output req_ready
  );
endinterface

// File: rtl/div_hilo_ctrl.sv
// HI/LO divide sequencer: accepts DIV/DIVU, drives an iterative restoring
// divider with operand magnitudes, sign-corrects the result into HI/LO and
// handles divide-by-zero plus mthi/mtlo writes.
// Optional build macro DIV_SHORTCUT_EN: when |a| < |b| the divider is skipped
// and the result (q=0, r=a) is written directly.
module div_hilo_ctrl #(
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  div_hilo_ctrl_if.slave         req,
  output logic                   div_start,
  output logic [31:0]            div_a,
  output logic [31:0]            div_b,
  input  logic [31:0]            div_q,
  input  logic [31:0]            div_r,
  input  logic                   hi_we,
  input  logic                   lo_we,
  input  logic [31:0]            wdata,
  output logic [31:0]            hi,
  output logic [31:0]            lo,
  output logic                   busy,
  output logic                   div_by_zero
);

  localparam int unsigned W     = 32;
  localparam int unsigned CNT_W = $clog2(DIV_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    START  = 2'd1,
    WAIT   = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             neg_q, neg_q_nx;
  logic             neg_r, neg_r_nx;
  logic             zero_f, zero_nx;
  logic             short_f, short_nx;
  logic [W-1:0]     a_orig, a_orig_nx;
  logic [W-1:0]     div_a_nx, div_b_nx;
  logic [W-1:0]     hi_nx, lo_nx;
  logic             div_start_nx, dbz_nx, busy_nx, ready_nx;

  logic             accept;
  logic [W-1:0]     mag_a, mag_b;
  logic             short_c;

  // Handshake and operand magnitudes (|0x80000000| stays 0x80000000).
  always_comb begin
    accept = req.req_valid && req.req_ready;
    mag_a  = (req.req_signed && req.req_a[W-1]) ? W'(-req.req_a) : req.req_a;
    mag_b  = (req.req_signed && req.req_b[W-1]) ? W'(-req.req_b) : req.req_b;
`ifdef DIV_SHORTCUT_EN
    short_c = (req.req_b != '0) && (mag_a < mag_b);
`else
    short_c = 1'b0;
`endif
  end

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    neg_q_nx  = neg_q;
    neg_r_nx  = neg_r;
    zero_nx   = zero_f;
    short_nx  = short_f;
    a_orig_nx = a_orig;
    div_a_nx  = div_a;
    div_b_nx  = div_b;
    hi_nx     = hi_we ? wdata : hi;
    lo_nx     = lo_we ? wdata : lo;

    case (state)
      IDLE: begin
        if (accept) begin
          neg_q_nx  = req.req_signed & (req.req_a[W-1] ^ req.req_b[W-1]);
          neg_r_nx  = req.req_signed & req.req_a[W-1];
          div_a_nx  = mag_a;
          div_b_nx  = mag_b;
          a_orig_nx = req.req_a;
          zero_nx   = (req.req_b == '0);
          short_nx  = short_c;
          state_nx  = ((req.req_b == '0) || short_c) ? FINISH : START;
        end
      end
      START: begin
        cnt_nx   = CNT_W'(DIV_CYCLES);
        state_nx = WAIT;
      end
      WAIT: begin
        cnt_nx = cnt - CNT_W'(1);
        if (cnt <= CNT_W'(1)) begin
          state_nx = FINISH;
        end
      end
      FINISH: begin
        // Division result takes priority over a same-cycle mthi/mtlo.
        if (zero_f) begin
          lo_nx = '1;
          hi_nx = a_orig;
        end else if (short_f) begin
          lo_nx = '0;
          hi_nx = a_orig;
        end else begin
          lo_nx = neg_q ? W'(-div_q) : div_q;
          hi_nx = neg_r ? W'(-div_r) : div_r;
        end
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase

    div_start_nx = (state_nx == START);
    dbz_nx       = (state_nx == FINISH) && zero_nx;
    busy_nx      = (state_nx != IDLE);
    ready_nx     = (state_nx == IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      neg_q         <= 1'b0;
      neg_r         <= 1'b0;
      zero_f        <= 1'b0;
      short_f       <= 1'b0;
      a_orig        <= '0;
      div_a         <= '0;
      div_b         <= '0;
      hi            <= '0;
      lo            <= '0;
      div_start     <= 1'b0;
      div_by_zero   <= 1'b0;
      busy          <= 1'b0;
      req.req_ready <= 1'b1;
    end else begin
      state         <= state_nx;
      cnt           <= cnt_nx;
      neg_q         <= neg_q_nx;
      neg_r         <= neg_r_nx;
      zero_f        <= zero_nx;
      short_f       <= short_nx;
      a_orig        <= a_orig_nx;
      div_a         <= div_a_nx;
      div_b         <= div_b_nx;
      hi            <= hi_nx;
      lo            <= lo_nx;
      div_start     <= div_start_nx;
      div_by_zero   <= dbz_nx;
      busy          <= busy_nx;
      req.req_ready <= ready_nx;
    end
  end

endmodule

// File: tb/tb_div_hilo_ctrl.sv
// Scoreboard bench for div_hilo_ctrl with a behavioural divider.
module tb_div_hilo_ctrl;

  localparam int unsigned DIV_CYCLES = 32;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        div_start;
  logic [31:0] div_a, div_b, div_q, div_r;
  logic        hi_we = 1'b0, lo_we = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] hi, lo;
  logic        busy, div_by_zero;

  div_hilo_ctrl_if rif ();

  div_hilo_ctrl #(.DIV_CYCLES(DIV_CYCLES)) dut (
    .clock       (clock),
    .reset       (reset),
    .req         (rif),
    .div_start   (div_start),
    .div_a       (div_a),
    .div_b       (div_b),
    .div_q       (div_q),
    .div_r       (div_r),
    .hi_we       (hi_we),
    .lo_we       (lo_we),
    .wdata       (wdata),
    .hi          (hi),
    .lo          (lo),
    .busy        (busy),
    .div_by_zero (div_by_zero)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic [31:0] ma;
    logic [31:0] mb;
    logic        zero;
    logic        start;
    int          lat;
    int          t_acc;
  } exp_t;

  exp_t sbq[$];

  // Reference: architectural DIV/DIVU semantics using 64-bit arithmetic.
  function automatic exp_t model(input logic s, input logic [31:0] a,
                                 input logic [31:0] b, input int t);
    exp_t   e;
    longint sa, sb, ma, mb, q, r;
    sa = s ? {{32{a[31]}}, a} : {32'b0, a};
    sb = s ? {{32{b[31]}}, b} : {32'b0, b};
    ma = (sa < 0) ? -sa : sa;
    mb = (sb < 0) ? -sb : sb;
    e.ma    = ma[31:0];
    e.mb    = mb[31:0];
    e.t_acc = t;
    if (b == 32'd0) begin
      e.lo = 32'hFFFF_FFFF; e.hi = a; e.zero = 1'b1; e.start = 1'b0; e.lat = 2;
    end else begin
      q = sa / sb;
      r = sa % sb;
      e.lo = q[31:0]; e.hi = r[31:0]; e.zero = 1'b0; e.start = 1'b1;
      e.lat = int'(DIV_CYCLES) + 3;
`ifdef DIV_SHORTCUT_EN
      if (ma < mb) begin e.start = 1'b0; e.lat = 2; end
`endif
    end
    return e;
  endfunction

  // Behavioural divider: outputs junk until DIV_CYCLES after start.
  logic [31:0] la = '0, lb = 1;
  int dcnt = 0;
  always @(posedge clock) begin
    if (reset) begin
      dcnt <= 0; div_q <= '0; div_r <= '0;
    end else if (div_start) begin
      la <= div_a; lb <= div_b; dcnt <= DIV_CYCLES;
      div_q <= $urandom; div_r <= $urandom;
    end else if (dcnt > 1) begin
      dcnt <= dcnt - 1; div_q <= $urandom; div_r <= $urandom;
    end else if (dcnt == 1) begin
      dcnt <= 0; div_q <= la / lb; div_r <= la % lb;
    end
  end

  // Monitor: checks start/zero pulses and pops results when busy drops.
  logic abort_mon = 1'b0;
  logic prev_busy = 1'b0;
  int   seen_start = 0, seen_dbz = 0;
  always @(negedge clock) begin
    if (abort_mon) begin
      abort_mon  = 1'b0;
      prev_busy  = 1'b0;
      seen_start = 0;
      seen_dbz   = 0;
    end else if (!reset) begin
      if (div_start) begin
        seen_start++;
        if (sbq.size() == 0) chk("start_unexpected", 32'd1, 32'd0);
        else begin
          chk("start_allowed", 32'd1, 32'(sbq[0].start));
          chk("start_cycle", 32'(cyc), 32'(sbq[0].t_acc + 1));
          chk("div_a", div_a, sbq[0].ma);
          chk("div_b", div_b, sbq[0].mb);
        end
      end
      if (div_by_zero) begin
        seen_dbz++;
        if (sbq.size() == 0) chk("dbz_unexpected", 32'd1, 32'd0);
        else chk("dbz_cycle", 32'(cyc), 32'(sbq[0].t_acc + 1));
      end
      if (prev_busy && !busy) begin
        if (sbq.size() == 0) chk("result_unexpected", 32'd1, 32'd0);
        else begin
          exp_t e;
          e = sbq.pop_front();
          chk("lo", lo, e.lo);
          chk("hi", hi, e.hi);
          chk("latency", 32'(cyc - e.t_acc), 32'(e.lat));
          chk("start_count", 32'(seen_start), 32'(e.start));
          chk("dbz_count", 32'(seen_dbz), 32'(e.zero));
        end
        seen_start = 0;
        seen_dbz   = 0;
      end
      prev_busy = busy;
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Present a request, hold until accepted, push its expectation.
  task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b);
    int w;
    rif.req_valid  = 1'b1;
    rif.req_signed = s;
    rif.req_a      = a;
    rif.req_b      = b;
    w = 0;
    while (!rif.req_ready && w < 200) begin
      wait_cycles(1);
      w++;
    end
    if (!rif.req_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      rif.req_valid = 1'b0;
      return;
    end
    sbq.push_back(model(s, a, b, cyc));
    wait_cycles(1);
    rif.req_valid = 1'b0;
    rif.req_a     = $urandom;
    rif.req_b     = $urandom;
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while ((busy || sbq.size() != 0) && w < 500) begin
      wait_cycles(1);
      w++;
    end
    if (busy || sbq.size() != 0) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rif.req_valid  = 1'b0;
    rif.req_signed = 1'b0;
    rif.req_a      = '0;
    rif.req_b      = '0;
    wait_cycles(3);
    reset = 1'b0;
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(rif.req_ready), 32'd1);
    chk("rst_div_a", div_a, 32'd0);
    chk("rst_div_b", div_b, 32'd0);
    chk("rst_start", 32'(div_start), 32'd0);

    // Directed cases.
    issue(1'b0, 32'd100, 32'd7);
    issue(1'b1, 32'hFFFF_FFF9, 32'd2);
    issue(1'b1, 32'd5, 32'd0);
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(1'b0, 32'd3, 32'd10);
    wait_idle();

    // mthi/mtlo in idle.
    hi_we = 1'b1; wdata = 32'h0000_5A5A;
    wait_cycles(1);
    hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h0000_A5A5;
    wait_cycles(1);
    lo_we = 1'b0;
    chk("mthi_idle", hi, 32'h0000_5A5A);
    chk("mtlo_idle", lo, 32'h0000_A5A5);

    // Accept with simultaneous mthi: write lands now, result later.
    hi_we = 1'b1; wdata = 32'h0000_1234;
    issue(1'b0, 32'd77, 32'd5);
    hi_we = 1'b0;
    chk("mthi_on_accept", hi, 32'h0000_1234);
    wait_idle();

    // mtlo during WAIT is visible until FINISH overwrites it.
    issue(1'b0, 32'd100, 32'd7);
    wait_cycles(4);
    lo_we = 1'b1; wdata = 32'h0000_00AA;
    wait_cycles(1);
    lo_we = 1'b0;
    chk("mtlo_wait", lo, 32'h0000_00AA);
    chk("busy_wait", 32'(busy), 32'd1);
    wait_idle();

    // mthi/mtlo in the FINISH cycle lose to the division write.
    issue(1'b0, 32'd1000, 32'd9);
    wait_cycles(int'(DIV_CYCLES) + 1);
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
    wait_cycles(1);
    hi_we = 1'b0; lo_we = 1'b0;
    wait_idle();

    // Reset in the middle of a divide.
    issue(1'b0, 32'd50, 32'd3);
    wait_cycles(9);
    reset = 1'b1;
    wait_cycles(1);
    reset = 1'b0;
    sbq.delete();
    abort_mon = 1'b1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    chk("abort_ready", 32'(rif.req_ready), 32'd1);
    wait_cycles(1);
    issue(1'b0, 32'd9, 32'd3);
    wait_idle();

    // Randomized back-to-back traffic.
    for (int i = 0; i < 40; i++) begin
      logic        s;
      logic [31:0] a, b;
      int          mode;
      s    = 1'($urandom_range(0, 1));
      mode = int'($urandom_range(0, 5));
      a    = $urandom;
      b    = $urandom;
      case (mode)
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = 32'($urandom_range(0, 40)); b = 32'($urandom_range(1, 40)); end
        3: b = b >> $urandom_range(0, 31);
        default: ;
      endcase
      issue(s, a, b);
    end
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
